warp_fetcher: RTL

- Instruction fetch stage directly upstream of the warp scheduler.
- When the scheduler's core_state is FETCH, fetches the 16-bit instruction at the current warp's PC and reports progress on fetcher_state. The scheduler advances to DECODE when it sees FETCHED.
- A small direct-mapped instruction cache serves repeated PCs (loops, warps sharing code) without a program-memory round trip.
- Misses use a valid/ready read handshake to the program memory controller.

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/warp_fetcher_if.sv | 35 +++
 rtl/warp_fetcher_icache_dm.sv | 65 ++++++
 rtl/warp_fetcher.sv | 135 +++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// ============================================================================
// Module      : gpu_pkg
// Description : Shared scheduler/fetcher state encodings and program memory
//               widths for the GPU core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

    localparam int c_PROGRAM_MEM_ADDR_BITS = 8;
    localparam int c_PROGRAM_MEM_DATA_BITS = 16;

    localparam logic [2:0] c_CORE_IDLE    = 3'b000;
    localparam logic [2:0] c_CORE_FETCH   = 3'b001;
    localparam logic [2:0] c_CORE_DECODE  = 3'b010;
    localparam logic [2:0] c_CORE_REQUEST = 3'b011;
    localparam logic [2:0] c_CORE_WAIT    = 3'b100;
    localparam logic [2:0] c_CORE_EXECUTE = 3'b101;
    localparam logic [2:0] c_CORE_UPDATE  = 3'b110;

    typedef enum logic [2:0] {
        FETCHER_IDLE = 3'b000,
        FETCHING     = 3'b001,
        FETCHED      = 3'b010
    } fetcher_state_t;

endpackage

`default_nettype wire

// File: rtl/warp_fetcher_if.sv
// ============================================================================
// Module      : warp_fetcher_if
// Description : Valid/ready read channel between the fetcher and the program
//               memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface warp_fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) ();

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );

endinterface

`default_nettype wire

// File: rtl/warp_fetcher_icache_dm.sv
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped instruction cache with combinational lookup,
//               single write port and whole-cache flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_dm #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    input  wire                  flush,
    input  wire [ADDR_BITS-1:0]  lookup_addr,
    output logic                 hit,
    output logic [DATA_BITS-1:0] rd_data,
    input  wire                  wr_en,
    input  wire [ADDR_BITS-1:0]  wr_addr,
    input  wire [DATA_BITS-1:0]  wr_data
);

    localparam int c_INDEX_BITS = $clog2(LINES);
    localparam int c_TAG_BITS   = ADDR_BITS - c_INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [c_TAG_BITS-1:0] r_tag  [LINES];
    logic [DATA_BITS-1:0]  r_data [LINES];

    logic [c_INDEX_BITS-1:0] w_lu_idx;
    logic [c_TAG_BITS-1:0]   w_lu_tag;
    logic [c_INDEX_BITS-1:0] w_wr_idx;
    logic [c_TAG_BITS-1:0]   w_wr_tag;

    assign w_lu_idx = lookup_addr[c_INDEX_BITS-1:0];
    assign w_lu_tag = lookup_addr[ADDR_BITS-1:c_INDEX_BITS];
    assign w_wr_idx = wr_addr[c_INDEX_BITS-1:0];
    assign w_wr_tag = wr_addr[ADDR_BITS-1:c_INDEX_BITS];

    // Flush wins over a same-cycle write and masks the same-cycle lookup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= wr_data;
        end
    end

    assign hit     = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag) && !flush;
    assign rd_data = r_data[w_lu_idx];

endmodule

`default_nettype wire

// File: rtl/warp_fetcher.sv
// ============================================================================
// Module      : warp_fetcher
// Description : Instruction fetch stage with a direct-mapped instruction cache
//               in front of the program memory read channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = c_PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = c_PROGRAM_MEM_DATA_BITS,
    parameter int CACHE_LINES           = 8
) (
    input  wire                              clk,
    input  wire                              reset,
    input  wire  [2:0]                       core_state,
    input  wire  [PROGRAM_MEM_ADDR_BITS-1:0] warp_pc,
    input  wire                              warp_skip,
    input  wire                              flush,
    warp_fetcher_if.master                   mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    fetcher_state_t                   r_state, w_state_next;
    logic                             r_valid, w_valid_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr, w_addr_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_pc, w_pc_next;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr, w_instr_next;
    logic [15:0]                      r_hits, r_misses;
    logic                             w_hit_inc, w_miss_inc, w_fill;
    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;

    icache_dm #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (CACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_addr (warp_pc),
        .hit         (w_hit),
        .rd_data     (w_hit_data),
        .wr_en       (w_fill),
        .wr_addr     (r_pc),
        .wr_data     (mem.mem_read_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= FETCHER_IDLE;
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_pc     <= '0;
            r_instr  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_addr  <= w_addr_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            if (w_hit_inc && r_hits != 16'hFFFF) begin
                r_hits <= r_hits + 16'd1;
            end
            if (w_miss_inc && r_misses != 16'hFFFF) begin
                r_misses <= r_misses + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_addr_next  = r_addr;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            FETCHER_IDLE: begin
                if (core_state == c_CORE_FETCH && !warp_skip) begin
                    w_pc_next = warp_pc;
                    if (w_hit) begin
                        w_instr_next = w_hit_data;
                        w_state_next = FETCHED;
                        w_hit_inc    = 1'b1;
                    end else begin
                        w_valid_next = 1'b1;
                        w_addr_next  = warp_pc;
                        w_state_next = FETCHING;
                        w_miss_inc   = 1'b1;
                    end
                end
            end
            FETCHING: begin
                if (mem.mem_read_ready) begin
                    w_instr_next = mem.mem_read_data;
                    w_valid_next = 1'b0;
                    w_state_next = FETCHED;
                    w_fill       = !flush;
                end
            end
            FETCHED: begin
                // A PC change while still in FETCH means the scheduler moved on.
                if (core_state == c_CORE_DECODE) begin
                    w_state_next = FETCHER_IDLE;
                end else if (core_state == c_CORE_FETCH && warp_pc != r_pc) begin
                    w_state_next = FETCHER_IDLE;
                end
            end
            default: begin
                w_state_next = FETCHER_IDLE;
            end
        endcase
    end

    assign fetcher_state        = r_state;
    assign instruction          = r_instr;
    assign hit_count            = r_hits;
    assign miss_count           = r_misses;
    assign mem.mem_read_valid   = r_valid;
    assign mem.mem_read_address = r_addr;

endmodule

`default_nettype wire
